// File: rtl/pace_pkg.sv
// ---------------------------------------------------------------------------
// pace_pkg
// Shared definitions for the PACE evaluator and the PACE parameter store.
// - pace_state_e   : evaluator FSM states
// - CoeffWords, PaceBounds, PaceParamWords, PaceParamWidth : layout of the
//   flat parameter vector for the default configuration
// - coeff_off / bound_off / eps_thr_off / eps_val_off : 32-bit word offsets
//   of each field inside the flat parameter vector
// ---------------------------------------------------------------------------
package pace_pkg;

  localparam int DefDegree   = 2;
  localparam int DefParts    = 16;
  localparam int DefFracBits = 16;
  localparam int DataWidth   = 32;

  localparam int CoeffWords     = DefParts * (DefDegree + 1);
  localparam int PaceBounds     = DefParts - 1;
  localparam int PaceParamWords = CoeffWords + PaceBounds + 2;
  localparam int PaceParamWidth = PaceParamWords * DataWidth;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEG  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } pace_state_e;

  // Coefficient k (k=0 is the constant term) of part p.
  function automatic int coeff_off(input int p, input int k, input int degree = DefDegree);
    return p * (degree + 1) + k;
  endfunction

  // Bound b sits right after all coefficient words.
  function automatic int bound_off(input int b, input int coeff_words = CoeffWords);
    return coeff_words + b;
  endfunction

  function automatic int eps_thr_off(input int coeff_words = CoeffWords,
                                     input int bounds = PaceBounds);
    return coeff_words + bounds;
  endfunction

  function automatic int eps_val_off(input int coeff_words = CoeffWords,
                                     input int bounds = PaceBounds);
    return coeff_words + bounds + 1;
  endfunction

endpackage

// File: rtl/pace_eval_unit_seg_sel.sv
// ---------------------------------------------------------------------------
// pace_seg_sel
// Combinational segment selector: compares signed x against PaceParts-1
// ascending bounds and returns the number of bounds that x reaches.
// x equal to a bound therefore selects the part above that bound.
// Ports:
//   x      in   32                    sample, signed
//   bounds in   (PaceParts-1)*32      bound[b] at bits b*32 +: 32
//   part   out  PartW                 selected part index
// ---------------------------------------------------------------------------
module pace_seg_sel
  import pace_pkg::*;
#(
  parameter int PaceParts = DefParts,
  parameter int PartW     = (PaceParts > 1) ? $clog2(PaceParts) : 1
) (
  input  logic [31:0]                 x,
  input  logic [(PaceParts-1)*32-1:0] bounds,
  output logic [PartW-1:0]            part
);

  // One comparator per bound; since bounds ascend, the count of bounds at or
  // below x is the index of the part x falls into.
  always_comb begin
    part = '0;
    for (int b = 0; b < PaceParts - 1; b++) begin
      if ($signed(x) >= $signed(bounds[b*32 +: 32])) begin
        part = part + PartW'(1);
      end
    end
  end

endmodule

// File: rtl/pace_eval_unit.sv
// ---------------------------------------------------------------------------
// pace_eval_unit
// Evaluates a piecewise polynomial f(x) on a valid/ready stream of signed
// Q(32-FracBits).FracBits samples: segment lookup, Horner evaluation and an
// optional small-|x| epsilon bypass. One sample in flight, fixed latency of
// PaceDegree+2 cycles from input handshake to out_valid_o.
// Configuration macro:
//   PACE_EVAL_SAT_EN  defined -> Horner multiply-shift and add saturate
//                     undefined -> two's-complement wrap
// Ports:
//   clk_i         in   1               clock
//   rst_i         in   1               synchronous reset, active-high
//   pace_param_i  in   ParamWidth      flat parameter vector (stable while busy)
//   in_valid_i    in   1               sample valid
//   in_ready_o    out  1               sample accepted when valid & ready
//   in_data_i     in   32              x
//   out_valid_o   out  1               result valid
//   out_ready_i   in   1               result consumed when valid & ready
//   out_data_o    out  32              f(x)
//   busy_o        out  1               high whenever not IDLE
// ---------------------------------------------------------------------------
module pace_eval_unit
  import pace_pkg::*;
#(
  parameter int PaceDegree    = DefDegree,
  parameter int PaceParts     = DefParts,
  parameter int PaceEps       = 1,
  parameter int PaceDataWidth = DataWidth,
  parameter int FracBits      = DefFracBits,
  localparam int NumCoeffWords = PaceParts * (PaceDegree + 1),
  localparam int NumBounds     = PaceParts - 1,
  localparam int ParamWidth    = (NumCoeffWords + NumBounds + 2) * PaceDataWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ParamWidth-1:0] pace_param_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_data_o,
  output logic                  busy_o
);

  localparam int PartW    = (PaceParts > 1) ? $clog2(PaceParts) : 1;
  localparam int CoefIdxW = (PaceDegree > 0) ? $clog2(PaceDegree + 1) : 1;

  if (PaceDataWidth != 32 || (PaceEps != 0 && PaceEps != 1)) begin : g_param_check
    $error("pace_eval_unit: PaceDataWidth must be 32 and PaceEps must be 0 or 1");
  end

  pace_state_e         state_q, state_d;
  logic [31:0]         x_q;
  logic [31:0]         acc_q;
  logic [31:0]         coef_q [PaceDegree+1];
  logic [CoefIdxW-1:0] k_q;
  logic                bypass_q;

  logic [PartW-1:0]    part;
  logic [31:0]         eps_thr;
  logic [31:0]         eps_val;
  logic [31:0]         x_abs;
  logic                eps_hit;

  assign eps_thr = pace_param_i[eps_thr_off(NumCoeffWords, NumBounds)*32 +: 32];
  assign eps_val = pace_param_i[eps_val_off(NumCoeffWords, NumBounds)*32 +: 32];

  pace_seg_sel #(
    .PaceParts (PaceParts),
    .PartW     (PartW)
  ) u_seg_sel (
    .x      (x_q),
    .bounds (pace_param_i[bound_off(0, NumCoeffWords)*32 +: NumBounds*32]),
    .part   (part)
  );

  // One Horner step: (acc*x) >>> FracBits on a full 64-bit signed product,
  // then add the next coefficient.
  function automatic logic [31:0] horner_step(input logic [31:0] acc,
                                              input logic [31:0] x,
                                              input logic [31:0] c);
    logic [63:0]        prod;
    logic signed [63:0] shifted;
`ifdef PACE_EVAL_SAT_EN
    logic [31:0]        ms;
    logic [32:0]        sum;
`endif
    prod    = {{32{acc[31]}}, acc} * {{32{x[31]}}, x};
    shifted = $signed(prod) >>> FracBits;
`ifdef PACE_EVAL_SAT_EN
    // The shifted product only fits 32 bits when bits 63..31 all agree.
    if (shifted[63:31] != {33{shifted[63]}}) begin
      ms = shifted[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      ms = shifted[31:0];
    end
    sum = {ms[31], ms} + {c[31], c};
    if (sum[32] != sum[31]) begin
      return sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return sum[31:0];
`else
    return 32'(shifted) + c;
`endif
  endfunction

  // |x| with the most negative value pinned to the largest positive one, so
  // the epsilon compare never sees a negative magnitude.
  always_comb begin
    if (x_q == 32'h8000_0000) begin
      x_abs = 32'h7FFF_FFFF;
    end else if (x_q[31]) begin
      x_abs = -x_q;
    end else begin
      x_abs = x_q;
    end
    eps_hit = (PaceEps == 1) && ($signed(x_abs) < $signed(eps_thr));
  end

  // State register; reset wins from any state, including mid-evaluation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs. The bypass case still walks through
  // EVAL so the latency does not depend on the data.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    busy_o      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) begin
          state_d = SEG;
        end
      end
      SEG: begin
        state_d = (PaceDegree == 0) ? DONE : EVAL;
      end
      EVAL: begin
        if (k_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        out_data_o  = bypass_q ? eps_val : acc_q;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch x on accept, snapshot the selected part's coefficients
  // in SEG, then run one Horner step per EVAL cycle from k=D-1 down to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      bypass_q <= 1'b0;
      for (int j = 0; j <= PaceDegree; j++) begin
        coef_q[j] <= '0;
      end
    end else begin
      if (state_q == IDLE && in_valid_i) begin
        x_q <= in_data_i;
      end
      if (state_q == SEG) begin
        for (int j = 0; j <= PaceDegree; j++) begin
          coef_q[j] <= pace_param_i[coeff_off(int'(part), j, PaceDegree)*32 +: 32];
        end
        acc_q    <= pace_param_i[coeff_off(int'(part), PaceDegree, PaceDegree)*32 +: 32];
        k_q      <= CoefIdxW'((PaceDegree > 0) ? PaceDegree - 1 : 0);
        bypass_q <= eps_hit;
      end
      if (state_q == EVAL) begin
        acc_q <= horner_step(acc_q, x_q, coef_q[k_q]);
        k_q   <= k_q - CoefIdxW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pace_eval_unit.sv
// ---------------------------------------------------------------------------
// tb_pace_eval_unit
// Directed and randomized stimulus for pace_eval_unit (D=2, 16 parts,
// FracBits=16), checked against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_pace_eval_unit;

  localparam int Degree     = 2;
  localparam int Parts      = 16;
  localparam int Bounds     = Parts - 1;
  localparam int CoeffWords = Parts * (Degree + 1);
  localparam int ParamWords = CoeffWords + Bounds + 2;
  localparam int ParamWidth = ParamWords * 32;
  localparam int Latency    = Degree + 2;
  localparam longint MaxI   = 64'sd2147483647;
  localparam longint MinI   = -64'sd2147483648;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [ParamWidth-1:0] pace_param_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [31:0]           out_data_o;
  logic                  busy_o;

  int words [ParamWords];
  int checks = 0;
  int errors = 0;

  pace_eval_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pace_param_i (pace_param_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: one Horner step in 64-bit integer arithmetic.
  function automatic int model_step(input int acc, input int x, input int c);
    longint shifted;
    longint sum;
    shifted = (longint'(acc) * longint'(x)) >>> 16;
`ifdef PACE_EVAL_SAT_EN
    if (shifted > MaxI) shifted = MaxI;
    if (shifted < MinI) shifted = MinI;
    sum = shifted + longint'(c);
    if (sum > MaxI) sum = MaxI;
    if (sum < MinI) sum = MinI;
    return int'(sum);
`else
    sum = longint'(int'(shifted)) + longint'(c);
    return int'(sum);
`endif
  endfunction

  // Reference model: part lookup, epsilon bypass and Horner evaluation.
  function automatic int model_eval(input int x);
    int part;
    int mag;
    int acc;
    part = 0;
    for (int b = 0; b < Bounds; b++) begin
      if (x >= words[CoeffWords + b]) part++;
    end
    if (x == int'(32'h8000_0000)) mag = int'(32'h7FFF_FFFF);
    else mag = (x < 0) ? -x : x;
    if (mag < words[CoeffWords + Bounds]) return words[CoeffWords + Bounds + 1];
    acc = words[part * (Degree + 1) + Degree];
    for (int k = Degree - 1; k >= 0; k--) begin
      acc = model_step(acc, x, words[part * (Degree + 1) + k]);
    end
    return acc;
  endfunction

  task automatic load_params();
    for (int i = 0; i < ParamWords; i++) begin
      pace_param_i[i*32 +: 32] = words[i];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offer one sample, then count cycles until out_valid_o (bounded).
  task automatic applyStimulus(input logic [31:0] x, output logic [31:0] data,
                               output int lat);
    @(negedge clk_i);
    checkOutput("in_ready idle", 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    in_data_i  = x;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_data_i  = $urandom;
    lat = 1;
    checkOutput("busy in flight", 32'(busy_o), 32'd1);
    while (!out_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    data = out_data_o;
  endtask

  task automatic releaseOutput();
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    checkOutput("out_valid after handshake", 32'(out_valid_o), 32'd0);
    checkOutput("in_ready after handshake", 32'(in_ready_o), 32'd1);
  endtask

  task automatic runSample(input string tag, input logic [31:0] x);
    logic [31:0] data;
    int          lat;
    applyStimulus(x, data, lat);
    checkOutput({tag, " data"}, data, 32'(model_eval(int'(x))));
    checkOutput({tag, " latency"}, 32'(lat), 32'(Latency));
    releaseOutput();
  endtask

  initial begin
    logic [31:0] data;
    logic [31:0] held;
    int          lat;
    int          xi;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    for (int i = 0; i < ParamWords; i++) words[i] = 0;
    for (int p = 0; p < Parts; p++) begin
      for (int k = 0; k <= Degree; k++) words[p*(Degree+1) + k] = int'($urandom_range(0, 32'h0004_0000));
    end
    words[0] = 32'h0001_0000;
    words[1] = 32'h0002_0000;
    words[2] = 32'h0003_0000;
    for (int b = 0; b < Bounds; b++) words[CoeffWords + b] = (b + 1) * 32'h0010_0000;
    load_params();

    // Reset state
    repeat (3) @(negedge clk_i);
    checkOutput("reset out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready_o), 32'd1);
    checkOutput("reset out_data", out_data_o, 32'd0);
    rst_i = 1'b0;

    // Basic evaluation: 3x^2 + 2x + 1 at x=2.0
    applyStimulus(32'h0002_0000, data, lat);
    checkOutput("basic data", data, 32'h0011_0000);
    checkOutput("basic model", data, 32'(model_eval(32'h0002_0000)));
    checkOutput("basic latency", 32'(lat), 32'(Latency));
    releaseOutput();

    // Segment boundaries
    runSample("bound3 exact", 32'(words[CoeffWords + 3]));
    runSample("bound14 plus1", 32'(words[CoeffWords + 14] + 1));
    runSample("most negative", 32'h8000_0000);

    // Epsilon bypass
    words[CoeffWords + Bounds]     = 32'h0000_0100;
    words[CoeffWords + Bounds + 1] = 32'h0000_0042;
    load_params();
    applyStimulus(32'hFFFF_FF80, data, lat);
    checkOutput("eps bypass data", data, 32'h0000_0042);
    checkOutput("eps bypass latency", 32'(lat), 32'(Latency));
    releaseOutput();
    runSample("eps at threshold", 32'h0000_0100);

    // Backpressure: result held while out_ready_i is low
    applyStimulus(32'h0003_8000, data, lat);
    held = data;
    checkOutput("bp data", data, 32'(model_eval(32'h0003_8000)));
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("bp data stable", out_data_o, held);
      checkOutput("bp in_ready low", 32'(in_ready_o), 32'd0);
      checkOutput("bp out_valid high", 32'(out_valid_o), 32'd1);
    end
    releaseOutput();

    // Reset while in EVAL
    @(negedge clk_i);
    in_valid_i = 1'b1;
    in_data_i  = 32'h0005_0000;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("mid-eval reset out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("mid-eval reset busy", 32'(busy_o), 32'd0);
    checkOutput("mid-eval reset in_ready", 32'(in_ready_o), 32'd1);
    repeat (5) @(negedge clk_i);
    checkOutput("post reset idle", 32'(out_valid_o), 32'd0);

    // Overflow in the Horner chain (x=256.0 lands in part 15)
    words[15*(Degree+1) + 0] = 0;
    words[15*(Degree+1) + 1] = 0;
    words[15*(Degree+1) + 2] = 32'h7FFF_0000;
    load_params();
    applyStimulus(32'h0100_0000, data, lat);
`ifdef PACE_EVAL_SAT_EN
    checkOutput("overflow data", data, 32'h7FFF_FFFF);
`else
    checkOutput("overflow data", data, 32'h0000_0000);
`endif
    checkOutput("overflow model", data, 32'(model_eval(32'h0100_0000)));
    releaseOutput();

    // Randomized samples and coefficients
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < CoeffWords; j++) words[j] = int'($urandom);
      load_params();
      if ($urandom_range(0, 3) == 0) xi = int'($urandom);
      else xi = int'($urandom_range(0, 32'h0240_0000)) - 32'h0120_0000;
      runSample("random", 32'(xi));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
